// File: rtl/latch_write_arbiter_if.sv
// Requester-side bus for latch_write_arbiter: write requests, per-requester data,
// one-hot grant/ack and a busy indication.
interface latch_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   busy;

  modport master (output req, wdata, input gnt, ack, busy);
  modport slave  (input req, wdata, output gnt, ack, busy);
endinterface

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin arbiter that owns the clk/d pins of one shared
// level-sensitive latch and runs a setup / transparent / hold sequence per write.
// Optional feature macro READBACK_CHECK_EN: adds q_in and a sticky readback
// mismatch flag (err); without it err is tied low and there is no q_in port.
//
// state | meaning
// IDLE  | latch closed, arbitrating pending requests from rr_ptr upward
// SETUP | winner's data on latch_d, latch still closed
// OPEN  | latch transparent for OPEN_CYC cycles
// HOLD  | latch closed, data held stable, ack pulsed to the winner
module latch_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter int OPEN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  latch_write_arbiter_if.slave bus,
  output logic                 latch_clk,
  output logic [WIDTH-1:0]     latch_d,
`ifdef READBACK_CHECK_EN
  input  logic [WIDTH-1:0]     q_in,
`endif
  output logic                 err
);

  localparam int PW  = $clog2(N_REQ);
  localparam int OCW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  localparam logic [OCW-1:0]   OPEN_LAST = OCW'(OPEN_CYC - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    LAST_REQ  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               latch_clk_q, latch_clk_d;
  logic [WIDTH-1:0]   latch_d_q, latch_d_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      winner_q, winner_d;
  logic [OCW-1:0]     open_cnt_q, open_cnt_d;

  logic [WIDTH-1:0]   slice [N_REQ];
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  int                 cand;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = bus.wdata[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: first pending request at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_found && bus.req[PW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  // Next-state and next-output logic for the write sequence.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    latch_clk_d = 1'b0;
    latch_d_d   = latch_d_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    open_cnt_d  = open_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d   = S_SETUP;
          gnt_d     = ONE_HOT0 << pick_idx;
          latch_d_d = slice[pick_idx];
          winner_d  = pick_idx;
        end
      end
      S_SETUP: begin
        state_d     = S_OPEN;
        latch_clk_d = 1'b1;
        open_cnt_d  = '0;
      end
      S_OPEN: begin
        open_cnt_d = open_cnt_q + 1'b1;
        if (open_cnt_q == OPEN_LAST) begin
          state_d = S_HOLD;
          ack_d   = gnt_q;
        end else begin
          latch_clk_d = 1'b1;
        end
      end
      S_HOLD: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (winner_q == LAST_REQ) ? '0 : winner_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM state and all registered outputs; reset aborts any write in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      latch_clk_q <= 1'b0;
      latch_d_q   <= '0;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      open_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      latch_clk_q <= latch_clk_d;
      latch_d_q   <= latch_d_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      open_cnt_q  <= open_cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign latch_clk = latch_clk_q;
  assign latch_d   = latch_d_q;

`ifdef READBACK_CHECK_EN
  logic err_q, err_d;

  // Readback compare in HOLD, when the latch is closed and must show latch_d.
  always_comb err_d = err_q | ((state_q == S_HOLD) && (q_in != latch_d_q));

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Testbench for latch_write_arbiter: directed sequences plus randomized traffic,
// checked by a transaction-level scoreboard and a behavioural latch model.
module tb_latch_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int OC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         latch_clk;
  logic [W-1:0] latch_d;
  logic         err;
  logic [W-1:0] latch_q;
`ifdef READBACK_CHECK_EN
  logic [W-1:0] q_in;
  logic         force_bad = 1'b0;
  assign q_in = force_bad ? '0 : latch_q;
`endif

  latch_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .OPEN_CYC(OC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .latch_clk (latch_clk),
    .latch_d   (latch_d),
`ifdef READBACK_CHECK_EN
    .q_in      (q_in),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  // The shared latch itself.
  always_latch if (latch_clk) latch_q <= latch_d;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  typedef struct {
    int           w;
    logic [W-1:0] data;
    int           ack_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   m_ptr     = 0;
  int   next_free = 0;
  int   m_w;

  // Reference model: a write occupies OC+3 cycles; winner is the first pending
  // requester at or after the pointer; data captured at the grant edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr     = 0;
      next_free = cyc + 1;
    end else if (cyc >= next_free && bus.req != 0) begin
      m_w = -1;
      for (int k = 0; k < N; k++) begin
        if (m_w < 0 && ((bus.req >> ((m_ptr + k) % N)) & 1) != 0) m_w = (m_ptr + k) % N;
      end
      exp_q.push_back('{w: m_w, data: W'(bus.wdata >> (m_w * W)), ack_cyc: cyc + 1 + OC});
      next_free = cyc + OC + 3;
      m_ptr     = (m_w + 1) % N;
    end
  end

  int           hi_cnt = 0;
  int           dchg   = 0;
  logic         prev_clk = 1'b0;
  logic [W-1:0] prev_d   = '0;
  exp_t         e_m;
  int           ack_log_w[$];
  int           ack_log_cyc[$];
  int           ack_log_d[$];

  // Monitor: pops the scoreboard whenever an ack appears.
  always @(negedge clk) begin
    if (!bus.busy) begin
      hi_cnt = 0;
      dchg   = 0;
    end else begin
      if (latch_clk) hi_cnt++;
      if (prev_clk && latch_d != prev_d) dchg = 1;
    end
    if (bus.ack != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 0);
      end else begin
        e_m = exp_q.pop_front();
        check("ack_onehot", 32'(bus.ack), 32'(1) << e_m.w);
        check("ack_cycle", cyc, e_m.ack_cyc);
        check("gnt_held", 32'(bus.gnt), 32'(1) << e_m.w);
        check("latch_d_hold", 32'(latch_d), 32'(e_m.data));
        check("latch_q_captured", 32'(latch_q), 32'(e_m.data));
        check("open_cycles", hi_cnt, OC);
        check("d_stable_open", dchg, 0);
        check("latch_clk_hold", 32'(latch_clk), 0);
        check("busy_hold", 32'(bus.busy), 1);
      end
      ack_log_w.push_back($clog2(int'(bus.ack)));
      ack_log_cyc.push_back(cyc);
      ack_log_d.push_back(int'(latch_d));
    end else if (exp_q.size() != 0 && cyc > exp_q[0].ack_cyc) begin
      check("missing_ack", 32'(bus.ack), 32'(1) << exp_q[0].w);
      void'(exp_q.pop_front());
    end
    prev_clk = latch_clk;
    prev_d   = latch_d;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    ack_log_w.delete();
    ack_log_cyc.delete();
    ack_log_d.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, input bit drop);
    int t;
    t = 0;
    while (ack_log_w.size() < n && t < budget) begin
      tick();
      t++;
      if (drop) bus.req = bus.req & ~bus.ack;
    end
    check("ack_wait", 32'(ack_log_w.size() >= n), 1);
  endtask

  task automatic wait_open();
    int t;
    t = 0;
    while (!latch_clk && t < 20) begin
      tick();
      t++;
    end
    check("open_wait", 32'(latch_clk), 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rnd_req;

  initial begin
    bus.req   = '1;
    bus.wdata = '0;
    // reset with all requests asserted
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_latch_clk", 32'(latch_clk), 0);
    check("rst_latch_d", 32'(latch_d), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(err), 0);
    bus.req = '0;
    rst_n   = 1'b1;
    tick();

    // single write from requester 1
    clear_logs();
    bus.wdata = 16'h00A0;
    bus.req   = 4'b0010;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'h2);
    check("single_latch_d", 32'(latch_d), 32'hA);
    check("single_setup_clk", 32'(latch_clk), 0);
    wait_acks(1, 20, 1'b1);
    if (ack_log_w.size() >= 1) check("single_winner", ack_log_w[0], 1);
    tick();
    check("single_q", 32'(latch_q), 32'hA);

    // fairness from reset with all requests held
    reset_dut();
    clear_logs();
    bus.wdata = 16'h4321;
    bus.req   = 4'hF;
    wait_acks(5, 60, 1'b0);
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      if (k < ack_log_w.size()) begin
        check("fair_order", ack_log_w[k], k % 4);
        check("fair_data", ack_log_d[k], (k % 4) + 1);
        if (k > 0) check("fair_spacing", ack_log_cyc[k] - ack_log_cyc[k-1], OC + 3);
      end
    end
    tick();

    // data change while the latch is transparent
    clear_logs();
    bus.wdata = 16'h0005;
    bus.req   = 4'b0001;
    wait_open();
    bus.wdata = 16'h000C;
    wait_acks(1, 20, 1'b1);
    if (ack_log_d.size() >= 1) check("stable_d", ack_log_d[0], 5);
    tick();
    check("stable_q", 32'(latch_q), 32'h5);

    // reset in the middle of OPEN
    clear_logs();
    bus.wdata = 16'h0070;
    bus.req   = 4'b0010;
    wait_acks(1, 20, 1'b1);
    bus.wdata = 16'h0900;
    bus.req   = 4'b0100;
    wait_open();
    rst_n   = 1'b0;
    bus.req = '0;
    tick();
    rst_n = 1'b1;
    check("abort_gnt", 32'(bus.gnt), 0);
    check("abort_latch_clk", 32'(latch_clk), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ack", 32'(bus.ack), 0);
    repeat (4) tick();
    check("abort_no_ack", ack_log_w.size(), 1);
    clear_logs();
    bus.wdata = 16'h3010;
    bus.req   = 4'b1010;
    wait_acks(1, 20, 1'b1);
    if (ack_log_w.size() >= 1) check("abort_ptr0_first", ack_log_w[0], 1);
    wait_acks(2, 20, 1'b1);
    if (ack_log_w.size() >= 2) check("abort_ptr0_second", ack_log_w[1], 3);
    bus.req = '0;
    tick();

`ifdef READBACK_CHECK_EN
    // readback mismatch is sticky until reset
    reset_dut();
    clear_logs();
    check("rb_err_clear", 32'(err), 0);
    force_bad = 1'b1;
    bus.wdata = 16'h0006;
    bus.req   = 4'b0001;
    wait_acks(1, 20, 1'b1);
    force_bad = 1'b0;
    check("rb_err_set", 32'(err), 1);
    bus.wdata = 16'h0003;
    bus.req   = 4'b0001;
    wait_acks(2, 20, 1'b1);
    check("rb_err_sticky", 32'(err), 1);
    reset_dut();
    check("rb_err_reset", 32'(err), 0);
`endif

    // randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      rnd_req = bus.req;
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          if ($urandom_range(0, 9) < 8) rnd_req[i] = 1'b0;
        end else if (!rnd_req[i]) begin
          if ($urandom_range(0, 9) < 3) rnd_req[i] = 1'b1;
        end else if (!bus.gnt[i] && $urandom_range(0, 19) == 0) begin
          rnd_req[i] = 1'b0;
        end
      end
      bus.req   = rnd_req;
      bus.wdata = (N*W)'($urandom());
      rst_n     = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n   = 1'b1;
    bus.req = '0;
    repeat (15) tick();
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", 32'(bus.busy), 0);
    check("final_err", 32'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
